// File: rtl/mips_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: op codes, FSM states,
// and the iteration count of the shift-add / restoring-divide loop.
package mips_pkg;

    localparam int MD_ITERS = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10
    } md_state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with private HI/LO and MFHI/MFLO/MTHI/MTLO.
// Both datapaths share one 2*WIDTH working register and the iteration counter.
module mul_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             mf_sel,
    output logic [WIDTH-1:0] mf_data,
    output logic             busy,
    output logic             done
);

    localparam int W2   = 2 * WIDTH;
    localparam int CNTW = $clog2(MD_ITERS);

    md_state_e        state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [W2-1:0]    work_q, work_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             is_div_q, is_div_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    // Operand magnitudes; |0x80000000| stays representable as unsigned.
    logic             signed_op;
    logic [WIDTH-1:0] mag_a, mag_b;
    assign signed_op = (op == MD_MULT) || (op == MD_DIV);
    assign mag_a     = (signed_op && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign mag_b     = (signed_op && rt_val[WIDTH-1]) ? -rt_val : rt_val;

    // Shift-add step: {acc, multiplier}, one multiplier bit per cycle, LSB first.
    logic [WIDTH:0]  mul_sum;
    logic [W2-1:0]   mul_step;
    assign mul_sum  = {1'b0, work_q[W2-1:WIDTH]} + (work_q[0] ? {1'b0, b_q} : '0);
    assign mul_step = {mul_sum, work_q[WIDTH-1:1]};

    // Restoring step: {remainder, dividend/quotient}, quotient bits shift in at LSB.
    // With a zero divisor the remainder ends up holding the raw dividend magnitude.
    logic [WIDTH:0]   div_trial;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;
    logic [W2-1:0]    div_step;
    assign div_trial = {work_q[W2-1:WIDTH], work_q[WIDTH-1]};
    assign div_ge    = div_trial >= {1'b0, b_q};
    assign div_rem   = div_ge ? WIDTH'(div_trial - {1'b0, b_q}) : div_trial[WIDTH-1:0];
    assign div_step  = {div_rem, work_q[WIDTH-2:0], div_ge};

    logic [W2-1:0]    prod_neg;
    logic [WIDTH-1:0] quot_neg, rem_neg;
    assign prod_neg = -work_q;
    assign quot_neg = -work_q[WIDTH-1:0];
    assign rem_neg  = -work_q[W2-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        b_d      = b_q;
        is_div_d = is_div_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    state_d  = MD_CALC;
                    cnt_d    = '0;
                    is_div_d = op[1];
                    sign_a_d = signed_op && rs_val[WIDTH-1];
                    sign_b_d = signed_op && rt_val[WIDTH-1];
                    work_d   = op[1] ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
                    b_d      = op[1] ? mag_b : mag_a;
                end else begin
                    if (mthi) hi_d = rs_val;
                    if (mtlo) lo_d = rs_val;
                end
            end
            MD_CALC: begin
                work_d = is_div_q ? div_step : mul_step;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNTW'(MD_ITERS - 1)) state_d = MD_FIX;
            end
            MD_FIX: begin
                state_d = MD_IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    lo_d = (b_q == '0) ? '1
                         : ((sign_a_q ^ sign_b_q) ? quot_neg : work_q[WIDTH-1:0]);
                    hi_d = sign_a_q ? rem_neg : work_q[W2-1:WIDTH];
                end else begin
                    {hi_d, lo_d} = (sign_a_q ^ sign_b_q) ? prod_neg : work_q;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            work_q   <= '0;
            b_q      <= '0;
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            b_q      <= b_d;
            is_div_q <= is_div_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign mf_data = mf_sel ? hi_q : lo_q;
    assign busy    = (state_q != MD_IDLE);
    assign done    = done_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: each task drives one scenario and
// compares against hand-computed HI/LO, latency and handshake values.
module tb_mul_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mthi;
    logic        mtlo;
    logic        mf_sel;
    logic [31:0] mf_data;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .mthi   (mthi),
        .mtlo   (mtlo),
        .mf_sel (mf_sel),
        .mf_data(mf_data),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launches one op from IDLE and steps until busy drops (bounded).
    // Returns busy cycle count and any done pulses seen while busy.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit inject, output int cyc, output int dones);
        op = o; rs_val = a; rt_val = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (inject && i == 5) begin
                start = 1'b1; mtlo = 1'b1; op = 2'b01;
                rs_val = 32'h5555_5555; rt_val = 32'h1;
            end
            @(posedge clk); #1;
            start = 1'b0; mtlo = 1'b0;
            cyc++;
            if (!busy) break;
            if (done) dones++;
        end
        $display("op=%b rs=%h rt=%h busy_cycles=%0d", o, a, b, cyc);
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        mf_sel = 1'b1; #1; hi = mf_data;
        mf_sel = 1'b0; #1; lo = mf_data;
    endtask

    task automatic test_reset();
        logic [31:0] hi, lo;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
        read_hilo(hi, lo);
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi: got %h expected 0", hi); end
        total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo: got %h expected 0", lo); end
        $display("reset check hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_mult();
        int cyc, dones;
        logic [31:0] hi, lo;
        run_op(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, cyc, dones);
        total++; if (cyc != 33) begin bad++; $display("FAIL mult_latency: got %0d expected 33", cyc); end
        total++; if (dones != 0) begin bad++; $display("FAIL mult_early_done: got %0d expected 0", dones); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL mult_done: got %b expected 1", done); end
        read_hilo(hi, lo);
        total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
        total++; if (lo !== 32'hFFFF_FFFA) begin bad++; $display("FAIL mult_lo: got %h expected fffffffa", lo); end
        @(posedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL mult_done_width: got %b expected 0", done); end
    endtask

    task automatic test_mult_wide();
        int cyc, dones;
        logic [31:0] hi, lo;
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, cyc, dones);
        read_hilo(hi, lo);
        total++; if (hi !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hi: got %h expected fffffffe", hi); end
        total++; if (lo !== 32'h0000_0001) begin bad++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, cyc, dones);
        read_hilo(hi, lo);
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL mult_m1_hi: got %h expected 00000000", hi); end
        total++; if (lo !== 32'h1) begin bad++; $display("FAIL mult_m1_lo: got %h expected 00000001", lo); end
    endtask

    task automatic test_div();
        int cyc, dones;
        logic [31:0] hi, lo;
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, cyc, dones);
        read_hilo(hi, lo);
        total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo: got %h expected fffffffd", lo); end
        total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi: got %h expected ffffffff", hi); end
        run_op(2'b11, 32'h0000_0007, 32'h0000_0000, 1'b0, cyc, dones);
        total++; if (cyc != 33) begin bad++; $display("FAIL div0_latency: got %0d expected 33", cyc); end
        read_hilo(hi, lo);
        total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div0_lo: got %h expected ffffffff", lo); end
        total++; if (hi !== 32'h0000_0007) begin bad++; $display("FAIL div0_hi: got %h expected 00000007", hi); end
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 1'b0, cyc, dones);
        read_hilo(hi, lo);
        total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sdiv0_lo: got %h expected ffffffff", lo); end
        total++; if (hi !== 32'hFFFF_FFF9) begin bad++; $display("FAIL sdiv0_hi: got %h expected fffffff9", hi); end
    endtask

    task automatic test_div_overflow_busy_ignore();
        int cyc, dones;
        logic [31:0] hi, lo;
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, cyc, dones);
        total++; if (cyc != 33) begin bad++; $display("FAIL ovf_latency: got %0d expected 33", cyc); end
        read_hilo(hi, lo);
        total++; if (lo !== 32'h8000_0000) begin bad++; $display("FAIL ovf_lo: got %h expected 80000000", lo); end
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL ovf_hi: got %h expected 00000000", hi); end
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ovf_no_restart: got busy=%b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        int cyc, dones;
        logic [31:0] hi, lo;
        rs_val = 32'h0000_AAAA; mthi = 1'b1;
        @(posedge clk); #1; mthi = 1'b0;
        rs_val = 32'h0000_1234; mtlo = 1'b1;
        @(posedge clk); #1; mtlo = 1'b0;
        mf_sel = 1'b0; #1;
        total++; if (mf_data !== 32'h0000_1234) begin bad++; $display("FAIL mtlo_read: got %h expected 00001234", mf_data); end
        mf_sel = 1'b1; #1;
        total++; if (mf_data !== 32'h0000_AAAA) begin bad++; $display("FAIL mthi_read: got %h expected 0000aaaa", mf_data); end
        $display("mt writes hi=%h lo=1234", mf_data);
        op = 2'b01; rs_val = 32'd3; rt_val = 32'd5; start = 1'b1; mthi = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy: got %b expected 1", busy); end
        mf_sel = 1'b1; #1;
        total++; if (mf_data !== 32'h0000_AAAA) begin bad++; $display("FAIL mthi_dropped: got %h expected 0000aaaa", mf_data); end
        mf_sel = 1'b0; #1;
        total++; if (mf_data !== 32'h0000_1234) begin bad++; $display("FAIL lo_held_busy: got %h expected 00001234", mf_data); end
        for (int i = 0; i < 40 && !done; i++) begin @(posedge clk); #1; end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_first_done: got %b expected 1", done); end
        read_hilo(hi, lo);
        total++; if (lo !== 32'd15 || hi !== 32'd0) begin bad++; $display("FAIL b2b_first: got %h_%h expected 00000000_0000000f", hi, lo); end
        run_op(2'b01, 32'd7, 32'd6, 1'b0, cyc, dones);
        total++; if (cyc != 33) begin bad++; $display("FAIL b2b_second_latency: got %0d expected 33", cyc); end
        read_hilo(hi, lo);
        total++; if (lo !== 32'd42) begin bad++; $display("FAIL b2b_second_lo: got %h expected 0000002a", lo); end
    endtask

    task automatic test_reset_mid_op();
        int cyc, dones;
        logic [31:0] hi, lo;
        op = 2'b01; rs_val = 32'hFFFF_FFFF; rt_val = 32'h1234_5678; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        #1; rst_n = 1'b0; #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done: got %b expected 0", done); end
        read_hilo(hi, lo);
        total++; if (hi !== 32'h0 || lo !== 32'h0) begin bad++; $display("FAIL midrst_hilo: got %h_%h expected 0_0", hi, lo); end
        $display("reset mid-op hi=%h lo=%h", hi, lo);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(2'b01, 32'd3, 32'd5, 1'b0, cyc, dones);
        read_hilo(hi, lo);
        total++; if (lo !== 32'd15) begin bad++; $display("FAIL post_rst_lo: got %h expected 0000000f", lo); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL post_rst_hi: got %h expected 00000000", hi); end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
        mthi = 1'b0; mtlo = 1'b0; mf_sel = 1'b0;
        #12;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_mult();
        test_mult_wide();
        test_div();
        test_div_overflow_busy_ignore();
        test_back_to_back();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
